alu_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one 8-bit ALU between two requesters. Each requester presents operands and a 2-bit operation with a valid/ready handshake. The block issues the operation to the ALU, waits a fixed latency, captures `f`/`cout` and returns them with a one-cycle response pulse to the requester that was served. It sits between the requesting logic and the ALU and is the only driver of the ALU's `a`, `b`, `s`, `L` and `En` inputs.

---
 rtl/alu_share_ctrl.sv | 107 ++++++++++
 tb/tb_alu_share_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one 8-bit ALU between two requesters.
// Issues a captured operation, waits LAT cycles, then returns the ALU result with a one-cycle pulse.
module alu_share_ctrl #(
    parameter int LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid_0,
    input  logic       req_valid_1,
    output logic       req_ready_0,
    output logic       req_ready_1,
    input  logic [7:0] req_a_0,
    input  logic [7:0] req_b_0,
    input  logic [7:0] req_a_1,
    input  logic [7:0] req_b_1,
    input  logic [1:0] req_s_0,
    input  logic [1:0] req_s_1,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_s,
    output logic       alu_L,
    output logic       alu_En,
    input  logic [7:0] alu_f,
    input  logic       alu_cout,
    output logic       rsp_valid_0,
    output logic       rsp_valid_1,
    output logic [7:0] rsp_f,
    output logic       rsp_cout,
    output logic       busy,
    output logic [7:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       last, id, grant_0, grant_1;
    logic [7:0] op_a, op_b;
    logic [1:0] op_s;

    // last == 1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        grant_0 = req_valid_0 && (!req_valid_1 || last);
        grant_1 = req_valid_1 && (!req_valid_0 || !last);
    end

    assign req_ready_0 = state == IDLE && grant_0 && reset;
    assign req_ready_1 = state == IDLE && grant_1 && reset;
    assign alu_a = op_a;
    assign alu_b = op_b;
    assign alu_s = op_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last        <= 1'b1;
            id          <= 1'b0;
            op_a        <= 8'd0;
            op_b        <= 8'd0;
            op_s        <= 2'd0;
            alu_L       <= 1'b0;
            alu_En      <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_f       <= 8'd0;
            rsp_cout    <= 1'b0;
            busy        <= 1'b0;
            done_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: if (req_ready_0 || req_ready_1) begin
                    state  <= ISSUE;
                    id     <= req_ready_1;
                    last   <= req_ready_1;
                    op_a   <= req_ready_1 ? req_a_1 : req_a_0;
                    op_b   <= req_ready_1 ? req_b_1 : req_b_0;
                    op_s   <= req_ready_1 ? req_s_1 : req_s_0;
                    alu_L  <= 1'b1;
                    alu_En <= 1'b1;
                    busy   <= 1'b1;
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= 4'(LAT - 1);
                    alu_L <= 1'b0;
                end
                WAIT: if (cnt == 4'd0) begin
                    state       <= RESP;
                    alu_En      <= 1'b0;
                    rsp_f       <= alu_f;
                    rsp_cout    <= alu_cout;
                    done_cnt    <= done_cnt + 8'd1;
                    rsp_valid_0 <= !id;
                    rsp_valid_1 <= id;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_0 <= 1'b0;
                    rsp_valid_1 <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench running every scenario on a LAT=1 and a LAT=3 instance.
module tb_alu_share_ctrl;
    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       rv0 [2], rv1 [2], rr0 [2], rr1 [2];
    logic [7:0] ra0 [2], rb0 [2], ra1 [2], rb1 [2];
    logic [1:0] rs0 [2], rs1 [2];
    logic [7:0] aa [2], ab [2], af [2];
    logic [1:0] asel [2];
    logic       al [2], aen [2], ac [2];
    logic       sv0 [2], sv1 [2], sc [2], bsy [2];
    logic [7:0] sf [2], dc [2];

    int checks = 0, errors = 0;
    int exp_done [2];
    int o_at, o_n, o_oth, o_l, o_en;
    logic [7:0] o_f, o_aw, o_hold;
    logic o_c, o_to;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int L = g ? 3 : 1;
        logic [8:0] pipe [L];
        alu_share_ctrl #(.LAT(L)) dut (
            .clock(clk), .reset(rst_n[g]),
            .req_valid_0(rv0[g]), .req_valid_1(rv1[g]),
            .req_ready_0(rr0[g]), .req_ready_1(rr1[g]),
            .req_a_0(ra0[g]), .req_b_0(rb0[g]), .req_a_1(ra1[g]), .req_b_1(rb1[g]),
            .req_s_0(rs0[g]), .req_s_1(rs1[g]),
            .alu_a(aa[g]), .alu_b(ab[g]), .alu_s(asel[g]), .alu_L(al[g]), .alu_En(aen[g]),
            .alu_f(af[g]), .alu_cout(ac[g]),
            .rsp_valid_0(sv0[g]), .rsp_valid_1(sv1[g]),
            .rsp_f(sf[g]), .rsp_cout(sc[g]), .busy(bsy[g]), .done_cnt(dc[g])
        );
        // ALU model: add for s=01, pass-through otherwise, LAT stages advancing while En
        always_ff @(posedge clk) begin
            if (aen[g]) begin
                pipe[0] <= (asel[g] == 2'b01) ? {1'b0, aa[g]} + {1'b0, ab[g]} : {1'b0, aa[g]};
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign af[g] = pipe[L-1][7:0];
        assign ac[g] = pipe[L-1][8];
    end

    function automatic int lat_of(input int k);
        return k ? 3 : 1;
    endfunction

    function automatic logic [41:0] outs(input int k);
        return {rr0[k], rr1[k], aa[k], ab[k], asel[k], al[k], aen[k], sv0[k], sv1[k], sf[k], sc[k], bsy[k], dc[k]};
    endfunction

    task automatic wait_ready(input int k, input bit who);
        int n = 0;
        #1;
        while (!(who ? rr1[k] : rr0[k]) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        o_to = (n == 20);
    endtask

    // One operation from a single requester; records what the DUT returned over a fixed window
    task automatic do_op(input int k, input bit who, input logic [7:0] a, input logic [7:0] b, input bit chg);
        @(negedge clk);
        if (who) begin ra1[k] = a; rb1[k] = b; rs1[k] = 2'b01; rv1[k] = 1'b1; end
        else begin ra0[k] = a; rb0[k] = b; rs0[k] = 2'b01; rv0[k] = 1'b1; end
        wait_ready(k, who);
        @(negedge clk);
        rv0[k] = 1'b0;
        rv1[k] = 1'b0;
        o_at = -1; o_n = 0; o_oth = 0; o_l = 0; o_en = 0;
        for (int i = 0; i < lat_of(k) + 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1 && chg) begin
                if (who) ra1[k] = ~a;
                else ra0[k] = ~a;
            end
            #1;
            if (i == 1) o_aw = aa[k];
            if (who ? sv1[k] : sv0[k]) begin
                if (o_at < 0) begin o_at = i; o_f = sf[k]; o_c = sc[k]; end
                o_n++;
            end
            if (who ? sv0[k] : sv1[k]) o_oth++;
            o_l += int'(al[k]);
            o_en += int'(aen[k]);
            if (i == lat_of(k) + 4) o_hold = sf[k];
        end
        exp_done[k] = (exp_done[k] + 1) % 256;
    endtask

    task automatic test_reset(input int k);
        rst_n[k] = 1'b0;
        rv0[k] = 1'b1;
        rv1[k] = 1'b1;
        #1;
        checks++; if (outs(k) !== '0) begin errors++; $display("FAIL reset_outs lat=%0d got %h exp 0", lat_of(k), outs(k)); end
        @(negedge clk);
        rst_n[k] = 1'b1;
        #1;
        checks++; if ({rr0[k], rr1[k]} !== 2'b10) begin errors++; $display("FAIL first_tie lat=%0d got %b exp 10", lat_of(k), {rr0[k], rr1[k]}); end
        rv0[k] = 1'b0;
        rv1[k] = 1'b0;
        exp_done[k] = 0;
    endtask

    task automatic test_single(input int k);
        do_op(k, 1'b0, 8'd20, 8'd30, 1'b0);
        checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL single_accept lat=%0d got timeout exp accept", lat_of(k)); end
        checks++; if (o_f !== 8'd50 || o_c !== 1'b0) begin errors++; $display("FAIL single_res lat=%0d got %0d/%0d exp 50/0", lat_of(k), o_f, o_c); end
        checks++; if (o_at != lat_of(k) + 1) begin errors++; $display("FAIL single_lat lat=%0d got %0d exp %0d", lat_of(k), o_at, lat_of(k) + 1); end
        checks++; if (o_n != 1 || o_oth != 0) begin errors++; $display("FAIL single_pulse lat=%0d got %0d/%0d exp 1/0", lat_of(k), o_n, o_oth); end
        checks++; if (dc[k] !== 8'd1) begin errors++; $display("FAIL single_done lat=%0d got %0d exp 1", lat_of(k), dc[k]); end
    endtask

    task automatic test_carry(input int k);
        do_op(k, 1'b1, 8'd200, 8'd100, 1'b0);
        checks++; if (o_f !== 8'd44 || o_c !== 1'b1) begin errors++; $display("FAIL carry_res lat=%0d got %0d/%0d exp 44/1", lat_of(k), o_f, o_c); end
        checks++; if (o_n != 1 || o_oth != 0 || o_at != lat_of(k) + 1) begin errors++; $display("FAIL carry_pulse lat=%0d got n=%0d oth=%0d at=%0d exp 1/0/%0d", lat_of(k), o_n, o_oth, o_at, lat_of(k) + 1); end
        checks++; if (o_l != 1) begin errors++; $display("FAIL carry_L lat=%0d got %0d exp 1", lat_of(k), o_l); end
        checks++; if (o_en != lat_of(k) + 1) begin errors++; $display("FAIL carry_En lat=%0d got %0d exp %0d", lat_of(k), o_en, lat_of(k) + 1); end
        checks++; if (dc[k] !== 8'd2) begin errors++; $display("FAIL carry_done lat=%0d got %0d exp 2", lat_of(k), dc[k]); end
    endtask

    task automatic test_contention(input int k);
        int g_who [4], g_t [4], r_f [4], r_who [4];
        int gc = 0, rc = 0, both = 0;
        @(negedge clk);
        ra0[k] = 8'd25; rb0[k] = 8'd30; rs0[k] = 2'b01;
        ra1[k] = 8'd35; rb1[k] = 8'd30; rs1[k] = 2'b01;
        rv0[k] = 1'b1;
        rv1[k] = 1'b1;
        for (int n = 0; n < 5 * lat_of(k) + 16; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (rr0[k] && rr1[k]) both++;
            if ((sv0[k] || sv1[k]) && rc < 4) begin r_f[rc] = int'(sf[k]); r_who[rc] = int'(sv1[k]); rc++; end
            if (gc == 4) begin rv0[k] = 1'b0; rv1[k] = 1'b0; end
            else if (rr0[k] || rr1[k]) begin g_who[gc] = int'(rr1[k]); g_t[gc] = n; gc++; end
        end
        checks++; if (both != 0) begin errors++; $display("FAIL cont_both_ready lat=%0d got %0d exp 0", lat_of(k), both); end
        checks++; if (gc != 4 || rc != 4) begin errors++; $display("FAIL cont_count lat=%0d got %0d/%0d exp 4/4", lat_of(k), gc, rc); end
        for (int i = 0; i < gc; i++) begin
            checks++; if (g_who[i] != i % 2) begin errors++; $display("FAIL cont_grant%0d lat=%0d got %0d exp %0d", i, lat_of(k), g_who[i], i % 2); end
            if (i > 0) begin
                checks++; if (g_t[i] - g_t[i-1] != lat_of(k) + 3) begin errors++; $display("FAIL cont_space%0d lat=%0d got %0d exp %0d", i, lat_of(k), g_t[i] - g_t[i-1], lat_of(k) + 3); end
            end
        end
        for (int i = 0; i < rc; i++) begin
            checks++; if (r_f[i] != (i % 2 ? 65 : 55) || r_who[i] != i % 2) begin errors++; $display("FAIL cont_rsp%0d lat=%0d got %0d/%0d exp %0d/%0d", i, lat_of(k), r_f[i], r_who[i], i % 2 ? 65 : 55, i % 2); end
        end
        exp_done[k] = exp_done[k] + 4;
        checks++; if (dc[k] !== 8'(exp_done[k])) begin errors++; $display("FAIL cont_done lat=%0d got %0d exp %0d", lat_of(k), dc[k], exp_done[k]); end
    endtask

    task automatic test_reset_mid(input int k);
        int seen = 0;
        @(negedge clk);
        ra0[k] = 8'd10; rb0[k] = 8'd10; rs0[k] = 2'b01;
        rv0[k] = 1'b1;
        wait_ready(k, 1'b0);
        @(negedge clk);
        rv0[k] = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({bsy[k], aen[k], al[k]} !== 3'b110) begin errors++; $display("FAIL mid_in_wait lat=%0d got %b exp 110", lat_of(k), {bsy[k], aen[k], al[k]}); end
        rst_n[k] = 1'b0;
        #1;
        checks++; if (outs(k) !== '0) begin errors++; $display("FAIL mid_reset_outs lat=%0d got %h exp 0", lat_of(k), outs(k)); end
        repeat (2) @(negedge clk);
        rst_n[k] = 1'b1;
        for (int i = 0; i < lat_of(k) + 4; i++) begin
            @(negedge clk);
            #1;
            seen += int'(sv0[k] | sv1[k] | bsy[k]);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp lat=%0d got %0d exp 0", lat_of(k), seen); end
        exp_done[k] = 0;
        do_op(k, 1'b0, 8'd40, 8'd30, 1'b0);
        checks++; if (o_f !== 8'd70 || o_n != 1) begin errors++; $display("FAIL mid_after lat=%0d got %0d/%0d exp 70/1", lat_of(k), o_f, o_n); end
        checks++; if (dc[k] !== 8'd1) begin errors++; $display("FAIL mid_done lat=%0d got %0d exp 1", lat_of(k), dc[k]); end
    endtask

    task automatic test_wrap_hold(input int k);
        int bad = 0;
        logic [8:0] e;
        for (int i = 0; i < 254; i++) begin
            e = 9'(i) + 9'd7;
            do_op(k, 1'(i % 2), 8'(i), 8'd7, 1'b0);
            if (o_f !== e[7:0] || o_c !== e[8] || o_n != 1 || o_to) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_ops lat=%0d got %0d bad exp 0", lat_of(k), bad); end
        checks++; if (dc[k] !== 8'd255) begin errors++; $display("FAIL wrap_255 lat=%0d got %0d exp 255", lat_of(k), dc[k]); end
        do_op(k, 1'b0, 8'd20, 8'd30, 1'b1);
        checks++; if (dc[k] !== 8'd0) begin errors++; $display("FAIL wrap_0 lat=%0d got %0d exp 0", lat_of(k), dc[k]); end
        checks++; if (o_aw !== 8'd20) begin errors++; $display("FAIL hold_alu_a lat=%0d got %0d exp 20", lat_of(k), o_aw); end
        checks++; if (o_f !== 8'd50 || o_hold !== 8'd50) begin errors++; $display("FAIL hold_res lat=%0d got %0d/%0d exp 50/50", lat_of(k), o_f, o_hold); end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            rv0[k] = 1'b0; rv1[k] = 1'b0;
            ra0[k] = 8'd0; rb0[k] = 8'd0; ra1[k] = 8'd0; rb1[k] = 8'd0;
            rs0[k] = 2'd0; rs1[k] = 2'd0;
            exp_done[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            test_reset(k);
            test_single(k);
            test_carry(k);
            test_contention(k);
            test_reset_mid(k);
            test_wrap_hold(k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
